// File: rtl/inst_fetch_ctrl_pkg.sv
// rtl/inst_fetch_ctrl_pkg.sv - shared constants and helpers for the instruction fetch controller
package inst_fetch_ctrl_pkg;

    // Instruction word issued to the IF stage whenever no valid word is available
    localparam logic [15:0] NOP_WORD_DEF = 16'h0800;

    // Fetch FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    localparam int MISS_CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [MISS_CNT_W-1:0] sat_inc(input logic [MISS_CNT_W-1:0] v);
        return (v == {MISS_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// rtl/icache_line_array.sv - register-based valid/tag/data store for one-word cache lines
module icache_line_array
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 13,
    parameter int DATA_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear_all,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [DATA_W-1:0]  i_wr_data,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [DATA_W-1:0]  o_rd_data
);

    localparam int LINES = 2 ** INDEX_W;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    // Valid bits: reset and clear_all take priority over a coincident write
    always_ff @(posedge clk) begin
        if (rst || i_clear_all) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag/data payload needs no reset; it is only trusted behind a valid bit
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - direct-mapped instruction fetch controller with RAM fill FSM
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                INDEX_W  = 3,
    parameter logic [DATA_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     data,
    output logic                  valid,
    output logic                  stall,
    input  logic                  flush,
    output logic                  ram_req,
    output logic [ADDR_W-1:0]     ram_addr,
    input  logic                  ram_ack,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic [MISS_CNT_W-1:0] miss_cnt
);

    localparam int TAG_W = ADDR_W - INDEX_W;

    logic [0:0]            r_state;
    logic                  r_cancel;
    logic                  r_ram_req;
    logic [ADDR_W-1:0]     r_ram_addr;
    logic [MISS_CNT_W-1:0] r_miss_cnt;

    logic                  w_rd_valid;
    logic [TAG_W-1:0]      w_rd_tag;
    logic [DATA_W-1:0]     w_rd_data;
    logic                  w_hit;
    logic                  w_fill_wr;

    // Fill writes go to the latched request address, never to the live PC,
    // so a redirect during FILL cannot misplace the returning word.
    assign w_fill_wr = (r_state == ST_FILL) && ram_ack && !r_cancel && !flush;

    icache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_lines (
        .clk         (clk),
        .rst         (rst),
        .i_clear_all (flush),
        .i_wr_en     (w_fill_wr),
        .i_wr_index  (r_ram_addr[INDEX_W-1:0]),
        .i_wr_tag    (r_ram_addr[ADDR_W-1:INDEX_W]),
        .i_wr_data   (ram_rdata),
        .i_rd_index  (addr[INDEX_W-1:0]),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data)
    );

    // Hits are only honoured in IDLE; during FILL the IF stage always sees a NOP
    assign w_hit = (r_state == ST_IDLE) && w_rd_valid && (w_rd_tag == addr[ADDR_W-1:INDEX_W]);

    assign data     = w_hit ? w_rd_data : NOP_WORD;
    assign valid    = w_hit;
    assign stall    = ~w_hit;
    assign ram_req  = r_ram_req;
    assign ram_addr = r_ram_addr;
    assign miss_cnt = r_miss_cnt;

    // Fetch FSM: issue a miss from IDLE, hold the request in FILL until the RAM acks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cancel   <= 1'b0;
            r_ram_req  <= 1'b0;
            r_ram_addr <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_hit && !flush) begin
                        r_state    <= ST_FILL;
                        r_ram_req  <= 1'b1;
                        r_ram_addr <= addr;
                        r_miss_cnt <= sat_inc(r_miss_cnt);
                    end
                end
                default: begin
                    if (ram_ack) begin
                        r_state   <= ST_IDLE;
                        r_ram_req <= 1'b0;
                        r_cancel  <= 1'b0;
                    end else if (flush) begin
                        // The RAM transaction still has to complete; just drop its data
                        r_cancel <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
